// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for the FIFO read-side controller
package fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int BUF_DEPTH      = 3;

    typedef enum logic {RUN, FLUSH} rd_state_e;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// rtl/fifo_rd_buf.sv - 3-entry circular output buffer with push, pop and clear
module fifo_rd_buf
    import fifo_pkg::*;
#(
    parameter int W = DEF_FIFO_WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    input  logic         clear_i,
    output logic [1:0]   occ_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] mem_q [BUF_DEPTH];
    logic [1:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]   occ_q, occ_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clear_i) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            occ_d    = 2'd0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            occ_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Head reads as zero when empty so m_data is defined after reset
    assign head_o = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - FIFO drain controller; FIFO_RD_CTRL_STATS_EN enables rd/drop counters
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [FIFO_WIDTH-1:0] data_out_i,
    input  logic                  empty_i,
    input  logic                  underflow_i,
    output logic                  rd_en_o,
    output logic [FIFO_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    input  logic                  flush_i,
    output logic                  flush_busy_o,
    output logic [CNT_WIDTH-1:0]  rd_count_o,
    output logic [CNT_WIDTH-1:0]  drop_count_o
);

    rd_state_e  state_q;
    logic       inflight_q;
    logic       flush_busy_q;
    logic [1:0] occ;
    logic       rd_en;
    logic       pop;
    logic       push;
    logic       flushing;

    assign flushing = (state_q == RUN) && flush_i;

    // Issue depends only on registered state, empty and flush, never on m_ready
    always_comb begin
        rd_en = 1'b0;
        if (state_q == RUN)
            rd_en = !flush_i && !empty_i
                    && (({1'b0, occ} + {2'b0, inflight_q}) < 3'(BUF_DEPTH));
        else
            rd_en = !empty_i && !inflight_q;
    end

    assign rd_en_o   = rd_en && !rst_i;
    assign m_valid_o = (state_q == RUN) && (occ != 2'd0);
    assign pop       = m_valid_o && m_ready_i;
    assign push      = inflight_q && !underflow_i && (state_q == RUN) && !flush_i;

    fifo_rd_buf #(.W(FIFO_WIDTH)) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (data_out_i),
        .pop_i       (pop),
        .clear_i     (flushing),
        .occ_o       (occ),
        .head_o      (m_data_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            inflight_q   <= 1'b0;
            flush_busy_q <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            case (state_q)
                RUN: if (flush_i) begin
                    state_q      <= FLUSH;
                    flush_busy_q <= 1'b1;
                end
                FLUSH: if (empty_i && !inflight_q) begin
                    state_q      <= RUN;
                    flush_busy_q <= 1'b0;
                end
                default: begin
                    state_q      <= RUN;
                    flush_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign flush_busy_o = flush_busy_q;

`ifdef FIFO_RD_CTRL_STATS_EN
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
    logic [2:0]           drop_inc;
    logic [CNT_WIDTH:0]   drop_sum;

    // On flush entry every buffered word not popped this cycle plus the in-flight word is lost
    always_comb begin
        if (flushing)
            drop_inc = {1'b0, occ} - {2'b0, pop} + {2'b0, inflight_q};
        else
            drop_inc = {2'b0, inflight_q && ((state_q == FLUSH) || underflow_i)};
        drop_sum     = {1'b0, drop_count_q} + (CNT_WIDTH+1)'(drop_inc);
        drop_count_d = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
        rd_count_d   = (pop && (rd_count_q != '1)) ? rd_count_q + 1'b1 : rd_count_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_count_q   <= '0;
            drop_count_q <= '0;
        end else begin
            rd_count_q   <= rd_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign rd_count_o   = rd_count_q;
    assign drop_count_o = drop_count_q;
`else
    assign rd_count_o   = '0;
    assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - directed self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

`ifdef FIFO_RD_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_i;
    logic [15:0] data_out_i;
    logic        empty_i;
    logic        underflow_i;
    logic        rd_en_o;
    logic [15:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic        flush_i;
    logic        flush_busy_o;
    logic [15:0] rd_count_o;
    logic [15:0] drop_count_o;

    int checks   = 0;
    int failures = 0;

    logic [15:0] fifo_q [$];

    fifo_rd_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .data_out_i   (data_out_i),
        .empty_i      (empty_i),
        .underflow_i  (underflow_i),
        .rd_en_o      (rd_en_o),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .flush_i      (flush_i),
        .flush_busy_o (flush_busy_o),
        .rd_count_o   (rd_count_o),
        .drop_count_o (drop_count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] cnt(input int n);
        return STATS ? 16'(n) : 16'd0;
    endfunction

    task automatic tick();
        logic rd;
        rd = rd_en_o;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) data_out_i = fifo_q.pop_front();
        underflow_i = 1'b0;
        empty_i = (fifo_q.size() == 0);
        #1;
    endtask

    task automatic fifo_load(input logic [15:0] w);
        fifo_q.push_back(w);
        empty_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        flush_i = 1'b0;
        m_ready_i = 1'b0;
        underflow_i = 1'b0;
        fifo_q.delete();
        empty_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0;
        m_ready_i = 1'b0;
        underflow_i = 1'b0;
        data_out_i = 16'h0;
        empty_i = 1'b1;

        fifo_load(16'hA5A5);
        tick();
        tick();
        checks++; if (rd_en_o !== 1'b0) begin failures++; $error("FAIL rst_rd_en observed=%0h expected=%0h", rd_en_o, 1'b0); end
        checks++; if (m_valid_o !== 1'b0) begin failures++; $error("FAIL rst_m_valid observed=%0h expected=%0h", m_valid_o, 1'b0); end
        checks++; if (m_data_o !== 16'h0) begin failures++; $error("FAIL rst_m_data observed=%0h expected=%0h", m_data_o, 16'h0); end
        checks++; if (flush_busy_o !== 1'b0) begin failures++; $error("FAIL rst_flush_busy observed=%0h expected=%0h", flush_busy_o, 1'b0); end
        checks++; if (rd_count_o !== 16'h0) begin failures++; $error("FAIL rst_rd_count observed=%0h expected=%0h", rd_count_o, 16'h0); end
        checks++; if (drop_count_o !== 16'h0) begin failures++; $error("FAIL rst_drop_count observed=%0h expected=%0h", drop_count_o, 16'h0); end
        rst_i = 1'b0;
        #1;
        checks++; if (rd_en_o !== 1'b1) begin failures++; $error("FAIL rel_rd_en_c1 observed=%0h expected=%0h", rd_en_o, 1'b1); end
        tick();
        checks++; if (m_valid_o !== 1'b0) begin failures++; $error("FAIL rel_m_valid_c1 observed=%0h expected=%0h", m_valid_o, 1'b0); end
        checks++; if (rd_en_o !== 1'b0) begin failures++; $error("FAIL rel_rd_en_empty observed=%0h expected=%0h", rd_en_o, 1'b0); end
        tick();
        checks++; if (m_valid_o !== 1'b1) begin failures++; $error("FAIL rel_m_valid_c2 observed=%0h expected=%0h", m_valid_o, 1'b1); end
        checks++; if (m_data_o !== 16'hA5A5) begin failures++; $error("FAIL rel_m_data_c2 observed=%0h expected=%0h", m_data_o, 16'hA5A5); end

        do_reset();
        for (int i = 1; i <= 8; i++) fifo_load(16'(i));
        m_ready_i = 1'b1;
        #1;
        checks++; if (rd_en_o !== 1'b1) begin failures++; $error("FAIL stream_rd_en_c0 observed=%0h expected=%0h", rd_en_o, 1'b1); end
        tick();
        tick();
        for (int i = 1; i <= 8; i++) begin
            checks++; if (m_valid_o !== 1'b1) begin failures++; $error("FAIL stream_m_valid observed=%0h expected=%0h", m_valid_o, 1'b1); end
            checks++; if (m_data_o !== 16'(i)) begin failures++; $error("FAIL stream_m_data observed=%0h expected=%0h", m_data_o, 16'(i)); end
            tick();
        end
        checks++; if (m_valid_o !== 1'b0) begin failures++; $error("FAIL stream_done_valid observed=%0h expected=%0h", m_valid_o, 1'b0); end
        checks++; if (rd_count_o !== cnt(8)) begin failures++; $error("FAIL stream_rd_count observed=%0h expected=%0h", rd_count_o, cnt(8)); end
        checks++; if (drop_count_o !== cnt(0)) begin failures++; $error("FAIL stream_drop_count observed=%0h expected=%0h", drop_count_o, cnt(0)); end

        do_reset();
        for (int i = 0; i < 10; i++) fifo_load(16'h0010 + 16'(i));
        m_ready_i = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (rd_en_o !== (k < 3)) begin failures++; $error("FAIL bp_rd_en observed=%0h expected=%0h", rd_en_o, (k < 3)); end
            if (k >= 3) begin
                checks++; if (m_data_o !== 16'h0010) begin failures++; $error("FAIL bp_m_data_stable observed=%0h expected=%0h", m_data_o, 16'h0010); end
            end
            tick();
        end
        checks++; if (m_valid_o !== 1'b1) begin failures++; $error("FAIL bp_hold_valid observed=%0h expected=%0h", m_valid_o, 1'b1); end
        checks++; if (m_data_o !== 16'h0010) begin failures++; $error("FAIL bp_hold_data observed=%0h expected=%0h", m_data_o, 16'h0010); end
        checks++; if (rd_en_o !== 1'b0) begin failures++; $error("FAIL bp_hold_rd_en observed=%0h expected=%0h", rd_en_o, 1'b0); end
        m_ready_i = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (m_valid_o !== 1'b1) begin failures++; $error("FAIL bp_out_valid observed=%0h expected=%0h", m_valid_o, 1'b1); end
            checks++; if (m_data_o !== 16'h0010 + 16'(k)) begin failures++; $error("FAIL bp_out_data observed=%0h expected=%0h", m_data_o, 16'h0010 + 16'(k)); end
            if (k == 1) begin
                checks++; if (rd_en_o !== 1'b1) begin failures++; $error("FAIL bp_resume_rd_en observed=%0h expected=%0h", rd_en_o, 1'b1); end
            end
            tick();
        end

        do_reset();
        for (int i = 0; i < 8; i++) fifo_load(16'h0020 + 16'(i));
        m_ready_i = 1'b0;
        #1;
        tick();
        tick();
        tick();
        flush_i = 1'b1;
        #1;
        checks++; if (rd_en_o !== 1'b0) begin failures++; $error("FAIL flush_rd_en_forced observed=%0h expected=%0h", rd_en_o, 1'b0); end
        checks++; if (m_valid_o !== 1'b1) begin failures++; $error("FAIL flush_cycle_valid observed=%0h expected=%0h", m_valid_o, 1'b1); end
        checks++; if (flush_busy_o !== 1'b0) begin failures++; $error("FAIL flush_cycle_busy observed=%0h expected=%0h", flush_busy_o, 1'b0); end
        tick();
        flush_i = 1'b0;
        #1;
        for (int k = 0; k <= 10; k++) begin
            if (k == 2) begin
                flush_i = 1'b1;
                #1;
            end
            checks++; if (flush_busy_o !== 1'b1) begin failures++; $error("FAIL flush_busy observed=%0h expected=%0h", flush_busy_o, 1'b1); end
            checks++; if (m_valid_o !== 1'b0) begin failures++; $error("FAIL flush_m_valid observed=%0h expected=%0h", m_valid_o, 1'b0); end
            checks++; if (rd_en_o !== ((k % 2 == 0) && (k <= 8))) begin failures++; $error("FAIL flush_rd_en observed=%0h expected=%0h", rd_en_o, ((k % 2 == 0) && (k <= 8))); end
            tick();
            flush_i = 1'b0;
        end
        #1;
        checks++; if (flush_busy_o !== 1'b0) begin failures++; $error("FAIL flush_exit_busy observed=%0h expected=%0h", flush_busy_o, 1'b0); end
        checks++; if (drop_count_o !== cnt(8)) begin failures++; $error("FAIL flush_drop_count observed=%0h expected=%0h", drop_count_o, cnt(8)); end
        checks++; if (rd_count_o !== cnt(0)) begin failures++; $error("FAIL flush_rd_count observed=%0h expected=%0h", rd_count_o, cnt(0)); end
        checks++; if (rd_en_o !== 1'b0) begin failures++; $error("FAIL flush_exit_rd_en observed=%0h expected=%0h", rd_en_o, 1'b0); end

        do_reset();
        for (int i = 0; i < 4; i++) fifo_load(16'h0030 + 16'(i));
        m_ready_i = 1'b0;
        #1;
        tick();
        underflow_i = 1'b1;
        #1;
        checks++; if (m_valid_o !== 1'b0) begin failures++; $error("FAIL uf_valid_c1 observed=%0h expected=%0h", m_valid_o, 1'b0); end
        tick();
        checks++; if (m_valid_o !== 1'b0) begin failures++; $error("FAIL uf_valid_c2 observed=%0h expected=%0h", m_valid_o, 1'b0); end
        checks++; if (drop_count_o !== cnt(1)) begin failures++; $error("FAIL uf_drop_count observed=%0h expected=%0h", drop_count_o, cnt(1)); end
        tick();
        checks++; if (m_valid_o !== 1'b1) begin failures++; $error("FAIL uf_valid_c3 observed=%0h expected=%0h", m_valid_o, 1'b1); end
        checks++; if (m_data_o !== 16'h0031) begin failures++; $error("FAIL uf_data_c3 observed=%0h expected=%0h", m_data_o, 16'h0031); end

        do_reset();
        for (int i = 0; i < 6; i++) fifo_load(16'h0040 + 16'(i));
        m_ready_i = 1'b0;
        #1;
        tick();
        tick();
        tick();
        checks++; if (m_data_o !== 16'h0040) begin failures++; $error("FAIL mrst_pre_data observed=%0h expected=%0h", m_data_o, 16'h0040); end
        rst_i = 1'b1;
        #1;
        checks++; if (rd_en_o !== 1'b0) begin failures++; $error("FAIL mrst_rd_en observed=%0h expected=%0h", rd_en_o, 1'b0); end
        checks++; if (m_valid_o !== 1'b0) begin failures++; $error("FAIL mrst_m_valid observed=%0h expected=%0h", m_valid_o, 1'b0); end
        checks++; if (m_data_o !== 16'h0) begin failures++; $error("FAIL mrst_m_data observed=%0h expected=%0h", m_data_o, 16'h0); end
        checks++; if (flush_busy_o !== 1'b0) begin failures++; $error("FAIL mrst_flush_busy observed=%0h expected=%0h", flush_busy_o, 1'b0); end
        tick();
        rst_i = 1'b0;
        #1;
        checks++; if (rd_en_o !== 1'b1) begin failures++; $error("FAIL mrst_rel_rd_en observed=%0h expected=%0h", rd_en_o, 1'b1); end
        tick();
        tick();
        checks++; if (m_valid_o !== 1'b1) begin failures++; $error("FAIL mrst_restart_valid observed=%0h expected=%0h", m_valid_o, 1'b1); end
        checks++; if (m_data_o !== 16'h0043) begin failures++; $error("FAIL mrst_restart_data observed=%0h expected=%0h", m_data_o, 16'h0043); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
